mvm_rx_dispatch: RTL and testbench

Parametrised AXI-Stream ingress dispatcher for the MVM tile, sitting between the NoC receive port and the tile datapath. It decodes each accepted flit by its `tuser` opcode and steers it to one of the following:
- a multi-bank register-file write port (bank-masked broadcast),
- an auto-incrementing instruction-memory write port,
- one of two buffered vector FIFOs (input vector, reduction vector) with independent valid/ready outputs.

It adds per-op backpressure, a parametrised bank count and FIFO depth, and a saturating drop counter for malformed flits.

---
 rtl/mvm_rx_dispatch.sv | 175 +++++++++++++++++
 tb/tb_mvm_rx_dispatch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_rx_dispatch.sv
// MVM tile ingress dispatcher: decodes AXI-Stream flits by tuser opcode and steers them
// to the RF write port, the instruction write port, or one of two vector FIFOs.

module mvm_rx_vfifo #(
    parameter int DATAW = 512,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DATAW-1:0] wdata,
    output logic             full,
    output logic             tvalid,
    output logic [DATAW-1:0] tdata,
    input  logic             tready
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;

    assign pop    = tvalid & tready;
    assign full   = (count == (AW+1)'(DEPTH));
    assign tvalid = (count != '0);
    assign tdata  = mem[rd_ptr];

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
endmodule

module mvm_rx_dispatch #(
    parameter int DATAW     = 512,
    parameter int USERW     = 75,
    parameter int RFADDRW   = 9,
    parameter int RFBANKS   = 64,
    parameter int INSTW     = 32,
    parameter int INSTD     = 512,
    parameter int INSTADDRW = $clog2(INSTD),
    parameter int VFIFOD    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 axis_rx_tvalid,
    input  logic [DATAW-1:0]     axis_rx_tdata,
    input  logic [USERW-1:0]     axis_rx_tuser,
    input  logic                 axis_rx_tlast,
    output logic                 axis_rx_tready,
    output logic [RFBANKS-1:0]   rf_wen,
    output logic [RFADDRW-1:0]   rf_waddr,
    output logic [DATAW-1:0]     rf_wdata,
    output logic                 inst_wen,
    output logic [INSTADDRW-1:0] inst_waddr,
    output logic [INSTW-1:0]     inst_wdata,
    input  logic                 inst_clr,
    output logic                 ivec_tvalid,
    output logic [DATAW-1:0]     ivec_tdata,
    input  logic                 ivec_tready,
    output logic                 rvec_tvalid,
    output logic [DATAW-1:0]     rvec_tdata,
    input  logic                 rvec_tready,
    output logic [15:0]          drop_cnt
);
    typedef enum logic [1:0] {
        OP_INST = 2'b00,
        OP_RVEC = 2'b01,
        OP_IVEC = 2'b10,
        OP_RF   = 2'b11
    } op_e;

    op_e                  op;
    logic [RFADDRW-1:0]   addr;
    logic [RFBANKS-1:0]   mask;
    logic                 accept;
    logic                 run;
    logic                 ivec_full;
    logic                 rvec_full;
    logic [INSTADDRW-1:0] inst_ptr;
    logic                 unused_ok;

    assign addr      = axis_rx_tuser[RFADDRW-1:0];
    assign op        = op_e'(axis_rx_tuser[RFADDRW+1:RFADDRW]);
    assign mask      = axis_rx_tuser[RFADDRW+2 +: RFBANKS];
    assign accept    = axis_rx_tvalid & axis_rx_tready;
    assign unused_ok = axis_rx_tlast ^ (^axis_rx_tuser);

    // run holds tready low until the first clock edge after reset release.
    always_comb begin
        axis_rx_tready = 1'b0;
        if (run) begin
            case (op)
                OP_RF, OP_INST: axis_rx_tready = 1'b1;
                OP_IVEC:        axis_rx_tready = !ivec_full;
                OP_RVEC:        axis_rx_tready = !rvec_full;
                default:        axis_rx_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run        <= 1'b0;
            rf_wen     <= '0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            inst_wen   <= 1'b0;
            inst_waddr <= '0;
            inst_wdata <= '0;
            inst_ptr   <= '0;
            drop_cnt   <= '0;
        end else begin
            run      <= 1'b1;
            rf_wen   <= '0;
            inst_wen <= 1'b0;
            if (accept && op == OP_RF) begin
                if (mask != '0) begin
                    rf_wen   <= mask;
                    rf_waddr <= addr;
                    rf_wdata <= axis_rx_tdata;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            if (accept && op == OP_INST) begin
                inst_wen   <= 1'b1;
                inst_waddr <= inst_ptr;
                inst_wdata <= axis_rx_tdata[INSTW-1:0];
            end
            // Clear wins over increment; the write above already used the old pointer.
            if (inst_clr)
                inst_ptr <= '0;
            else if (accept && op == OP_INST)
                inst_ptr <= (inst_ptr == INSTADDRW'(INSTD - 1)) ? '0 : inst_ptr + 1'b1;
        end
    end

    mvm_rx_vfifo #(.DATAW(DATAW), .DEPTH(VFIFOD)) u_ivec (
        .clk    (clk),
        .rst    (rst),
        .push   (accept && op == OP_IVEC),
        .wdata  (axis_rx_tdata),
        .full   (ivec_full),
        .tvalid (ivec_tvalid),
        .tdata  (ivec_tdata),
        .tready (ivec_tready)
    );

    mvm_rx_vfifo #(.DATAW(DATAW), .DEPTH(VFIFOD)) u_rvec (
        .clk    (clk),
        .rst    (rst),
        .push   (accept && op == OP_RVEC),
        .wdata  (axis_rx_tdata),
        .full   (rvec_full),
        .tvalid (rvec_tvalid),
        .tdata  (rvec_tdata),
        .tready (rvec_tready)
    );
endmodule

// File: tb/tb_mvm_rx_dispatch.sv
// Directed self-checking bench for mvm_rx_dispatch: RF writes, vector FIFOs,
// instruction pointer wrap/clear, drop counter saturation and mid-operation reset.

module tb_mvm_rx_dispatch;
    localparam int DATAW     = 512;
    localparam int USERW     = 75;
    localparam int RFADDRW   = 9;
    localparam int RFBANKS   = 64;
    localparam int INSTW     = 32;
    localparam int INSTD     = 512;
    localparam int INSTADDRW = 9;
    localparam int VFIFOD    = 16;

    logic                 clk;
    logic                 rst;
    logic                 axis_rx_tvalid;
    logic [DATAW-1:0]     axis_rx_tdata;
    logic [USERW-1:0]     axis_rx_tuser;
    logic                 axis_rx_tlast;
    logic                 axis_rx_tready;
    logic [RFBANKS-1:0]   rf_wen;
    logic [RFADDRW-1:0]   rf_waddr;
    logic [DATAW-1:0]     rf_wdata;
    logic                 inst_wen;
    logic [INSTADDRW-1:0] inst_waddr;
    logic [INSTW-1:0]     inst_wdata;
    logic                 inst_clr;
    logic                 ivec_tvalid;
    logic [DATAW-1:0]     ivec_tdata;
    logic                 ivec_tready;
    logic                 rvec_tvalid;
    logic [DATAW-1:0]     rvec_tdata;
    logic                 rvec_tready;
    logic [15:0]          drop_cnt;

    int checks = 0;
    int errors = 0;

    mvm_rx_dispatch #(
        .DATAW(DATAW), .USERW(USERW), .RFADDRW(RFADDRW), .RFBANKS(RFBANKS),
        .INSTW(INSTW), .INSTD(INSTD), .INSTADDRW(INSTADDRW), .VFIFOD(VFIFOD)
    ) dut (
        .clk(clk), .rst(rst),
        .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tdata(axis_rx_tdata),
        .axis_rx_tuser(axis_rx_tuser), .axis_rx_tlast(axis_rx_tlast),
        .axis_rx_tready(axis_rx_tready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .inst_wen(inst_wen), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
        .inst_clr(inst_clr),
        .ivec_tvalid(ivec_tvalid), .ivec_tdata(ivec_tdata), .ivec_tready(ivec_tready),
        .rvec_tvalid(rvec_tvalid), .rvec_tdata(rvec_tdata), .rvec_tready(rvec_tready),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [RFADDRW-1:0] addr,
                         input logic [RFBANKS-1:0] mask, input logic [DATAW-1:0] data);
        axis_rx_tvalid = 1'b1;
        axis_rx_tuser  = {mask, op, addr};
        axis_rx_tdata  = data;
    endtask

    // Holds the flit until accepted; returns on the falling edge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [RFADDRW-1:0] addr,
                        input logic [RFBANKS-1:0] mask, input logic [DATAW-1:0] data);
        bit done;
        done = 1'b0;
        drive(op, addr, mask, data);
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (axis_rx_tready === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        if (!done) check("send_accept", DATAW'(done), DATAW'(1));
    endtask

    task automatic idle();
        axis_rx_tvalid = 1'b0;
        axis_rx_tuser  = '0;
        @(negedge clk);
    endtask

    logic [RFBANKS-1:0] mask_a;
    logic [DATAW-1:0]   inst_data;
    int                 exp_ptr;

    initial begin
        rst = 1'b0;
        axis_rx_tlast = 1'b1;
        inst_clr = 1'b0;
        ivec_tready = 1'b0;
        rvec_tready = 1'b0;
        mask_a = 64'h1111111111111111;
        drive(2'b11, 9'h1, mask_a, {64{8'h01}});

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tready", DATAW'(axis_rx_tready), DATAW'(0));
        check("rst_rf_wen", DATAW'(rf_wen), DATAW'(0));
        check("rst_rf_wdata", rf_wdata, '0);
        check("rst_inst_wen", DATAW'(inst_wen), DATAW'(0));
        check("rst_inst_waddr", DATAW'(inst_waddr), DATAW'(0));
        check("rst_ivec_tvalid", DATAW'(ivec_tvalid), DATAW'(0));
        check("rst_rvec_tvalid", DATAW'(rvec_tvalid), DATAW'(0));
        check("rst_drop_cnt", DATAW'(drop_cnt), DATAW'(0));
        axis_rx_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // RF write, one-cycle pulse
        send(2'b11, 9'h1, mask_a, {64{8'h01}});
        check("rf_wen", DATAW'(rf_wen), DATAW'(mask_a));
        check("rf_waddr", DATAW'(rf_waddr), DATAW'(1));
        check("rf_wdata", rf_wdata, {64{8'h01}});
        check("rf_no_inst_wen", DATAW'(inst_wen), DATAW'(0));
        idle();
        check("rf_wen_one_cycle", DATAW'(rf_wen), DATAW'(0));

        // Input-vector FIFO fill, stall, drain
        for (int i = 0; i < VFIFOD; i++) send(2'b10, '0, '0, DATAW'(i));
        check("ivec_valid_full", DATAW'(ivec_tvalid), DATAW'(1));
        drive(2'b10, '0, '0, DATAW'(VFIFOD));
        #1;
        check("ivec_full_tready", DATAW'(axis_rx_tready), DATAW'(0));
        ivec_tready = 1'b1;
        for (int k = 0; k <= VFIFOD; k++) begin
            check("ivec_drain_valid", DATAW'(ivec_tvalid), DATAW'(1));
            check("ivec_drain_data", ivec_tdata, DATAW'(k));
            if (k == 0) check("ivec_tready_still_full", DATAW'(axis_rx_tready), DATAW'(0));
            if (k == 1) check("ivec_tready_recover", DATAW'(axis_rx_tready), DATAW'(1));
            @(negedge clk);
            if (k == 1) axis_rx_tvalid = 1'b0;
            #1;
        end
        check("ivec_empty", DATAW'(ivec_tvalid), DATAW'(0));
        ivec_tready = 1'b0;
        @(negedge clk);

        // Instruction pointer wrap and clear
        inst_data = {{15{32'hDEADBEEF}}, 32'h800000CC};
        for (int i = 0; i < INSTD + 2; i++) begin
            send(2'b00, 9'h1AB, '0, inst_data);
            check("inst_wen", DATAW'(inst_wen), DATAW'(1));
            check("inst_waddr", DATAW'(inst_waddr), DATAW'(i % INSTD));
            check("inst_wdata", DATAW'(inst_wdata), DATAW'(32'h800000CC));
        end
        check("inst_no_drop", DATAW'(drop_cnt), DATAW'(0));
        inst_clr = 1'b1;
        send(2'b00, '0, '0, inst_data);
        inst_clr = 1'b0;
        check("inst_clr_same_cycle_addr", DATAW'(inst_waddr), DATAW'(2));
        send(2'b00, '0, '0, inst_data);
        check("inst_after_clr_addr", DATAW'(inst_waddr), DATAW'(0));
        idle();
        check("inst_wen_low", DATAW'(inst_wen), DATAW'(0));
        inst_clr = 1'b1;
        idle();
        inst_clr = 1'b0;
        send(2'b00, '0, '0, inst_data);
        check("inst_clr_idle_addr", DATAW'(inst_waddr), DATAW'(0));
        exp_ptr = 1;

        // Dropped RF writes and saturation
        send(2'b11, 9'h5, '0, {64{8'h5A}});
        check("drop_no_rf_wen", DATAW'(rf_wen), DATAW'(0));
        check("drop_cnt_1", DATAW'(drop_cnt), DATAW'(1));
        for (int i = 0; i < 65534; i++) send(2'b11, 9'h5, '0, '0);
        check("drop_cnt_max", DATAW'(drop_cnt), DATAW'(16'hFFFF));
        send(2'b11, 9'h5, '0, '0);
        check("drop_cnt_sat", DATAW'(drop_cnt), DATAW'(16'hFFFF));
        idle();

        // Mixed ops with reduction FIFO stalled
        ivec_tready = 1'b1;
        rvec_tready = 1'b0;
        for (int r = 0; r < VFIFOD; r++) begin
            send(2'b11, RFADDRW'(r), RFBANKS'(1) << r, {64{8'h03}} ^ DATAW'(r));
            check("mix_rf_wen", DATAW'(rf_wen), DATAW'(RFBANKS'(1) << r));
            check("mix_rf_waddr", DATAW'(rf_waddr), DATAW'(r));
            check("mix_rf_wdata", rf_wdata, {64{8'h03}} ^ DATAW'(r));
            send(2'b10, '0, '0, DATAW'(100 + r));
            check("mix_ivec_data", ivec_tdata, DATAW'(100 + r));
            send(2'b01, '0, '0, {64{8'h02}});
            check("mix_rvec_valid", DATAW'(rvec_tvalid), DATAW'(1));
            send(2'b00, '0, '0, DATAW'(r));
            check("mix_inst_waddr", DATAW'(inst_waddr), DATAW'(exp_ptr));
            check("mix_inst_wdata", DATAW'(inst_wdata), DATAW'(r));
            exp_ptr++;
        end
        drive(2'b01, '0, '0, {64{8'h02}});
        #1;
        check("rvec_full_tready", DATAW'(axis_rx_tready), DATAW'(0));
        axis_rx_tvalid = 1'b0;
        axis_rx_tuser = {64'h0, 2'b11, 9'h0};
        #1;
        check("rf_tready_rvec_full", DATAW'(axis_rx_tready), DATAW'(1));
        axis_rx_tuser = {64'h0, 2'b10, 9'h0};
        #1;
        check("ivec_tready_rvec_full", DATAW'(axis_rx_tready), DATAW'(1));
        rvec_tready = 1'b1;
        for (int k = 0; k < VFIFOD; k++) begin
            check("rvec_drain_valid", DATAW'(rvec_tvalid), DATAW'(1));
            check("rvec_drain_data", rvec_tdata, {64{8'h02}});
            @(negedge clk);
            #1;
        end
        check("rvec_empty", DATAW'(rvec_tvalid), DATAW'(0));
        rvec_tready = 1'b0;
        ivec_tready = 1'b0;
        @(negedge clk);

        // Reset mid-operation
        send(2'b00, '0, '0, DATAW'(77));
        for (int i = 0; i < 3; i++) send(2'b10, '0, '0, DATAW'(7 + i));
        check("pre_rst_ivec_valid", DATAW'(ivec_tvalid), DATAW'(1));
        check("pre_rst_inst_waddr", DATAW'(inst_waddr), DATAW'(exp_ptr));
        drive(2'b11, 9'h3, mask_a, '1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ivec_valid", DATAW'(ivec_tvalid), DATAW'(0));
        check("midrst_tready", DATAW'(axis_rx_tready), DATAW'(0));
        check("midrst_inst_waddr", DATAW'(inst_waddr), DATAW'(0));
        axis_rx_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("postrst_ivec_empty", DATAW'(ivec_tvalid), DATAW'(0));
        check("postrst_inst_waddr", DATAW'(inst_waddr), DATAW'(0));
        check("postrst_rf_wen", DATAW'(rf_wen), DATAW'(0));
        send(2'b00, '0, '0, DATAW'(5));
        check("postrst_ptr_zero", DATAW'(inst_waddr), DATAW'(0));
        send(2'b10, '0, '0, DATAW'(42));
        check("postrst_ivec_first", ivec_tdata, DATAW'(42));
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
